// File: rtl/ialm_pkg.sv
// ialm_pkg: shared widths and types for the IALM approximate multiplier
// back end (log-to-linear conversion).
//   CHAR_W   - characteristic (integer log2) width
//   FRAC_W   - mantissa width
//   PROD_W   - linear product width (16x16 unsigned)
//   CHAR_SAT - characteristic value that saturates the product
//   SHIFT_W  - intermediate width of the mantissa shifter
package ialm_pkg;

    localparam int CHAR_W   = 5;
    localparam int FRAC_W   = 15;
    localparam int PROD_W   = 32;
    localparam int SUM_W    = CHAR_W + FRAC_W;
    localparam int M_W      = FRAC_W + 1;
    localparam int SHIFT_W  = M_W + 30;
    localparam logic [CHAR_W-1:0] CHAR_SAT = 5'd31;

    // Stage-1 payload: restored mantissa plus decoded control.
    typedef struct packed {
        logic [M_W-1:0]    m;
        logic [CHAR_W-1:0] sh;
        logic              z;
        logic              sat;
    } s1_t;

endpackage

// File: rtl/antilog_shift.sv
// antilog_shift: combinational antilog core.
//   i_m       - mantissa with hidden one restored, {1'b1, frac}
//   i_sh      - characteristic (left shift amount)
//   i_z       - an operand was zero, force product to 0
//   i_sat     - characteristic at saturation value, force all ones
//   o_product - floor(i_m * 2^i_sh / 2^FRAC_W)
module antilog_shift
    import ialm_pkg::*;
(
    input  logic [M_W-1:0]    i_m,
    input  logic [CHAR_W-1:0] i_sh,
    input  logic              i_z,
    input  logic              i_sat,
    output logic [PROD_W-1:0] o_product
);

    logic [SHIFT_W-1:0] w_ext;
    logic [SHIFT_W-1:0] w_shl;
    logic               w_unused_frac;

    assign w_ext = {{(SHIFT_W-M_W){1'b0}}, i_m};
    // Non-saturated shifts are at most 30, so the top result bit lands in
    // w_shl[45] and the linear value fits in 31 bits.
    assign w_shl = w_ext << i_sh;
    // Bits below the binary point are truncated away (floor).
    assign w_unused_frac = ^w_shl[FRAC_W-1:0];

    always_comb begin
        o_product = {{(PROD_W-(SHIFT_W-FRAC_W)){1'b0}}, w_shl[SHIFT_W-1:FRAC_W]};
        if (i_z)
            o_product = '0;
        else if (i_sat)
            o_product = '1;
    end

endmodule

// File: rtl/antilog_pipe.sv
// antilog_pipe: two-stage valid/ready log-to-linear converter.
//   clk, rst_n           - clock, async active-low reset
//   in_valid/in_ready    - input handshake for sumlog/in_zero
//   sumlog               - {char[4:0], frac[14:0]} log-domain sum
//   in_zero              - an operand was zero, product forced to 0
//   out_valid/out_ready  - output handshake for product
//   product              - approximate linear product
// Stage 1 registers the decoded operand, stage 2 registers the product.
module antilog_pipe
    import ialm_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SUM_W-1:0]  sumlog,
    input  logic              in_zero,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PROD_W-1:0] product
);

    logic              r_s1_valid;
    s1_t               r_s1;
    logic              r_s2_valid;
    logic [PROD_W-1:0] r_s2_product;

    logic              w_s2_load;
    logic              w_s1_adv;
    logic              w_accept;
    logic [CHAR_W-1:0] w_char;
    logic [FRAC_W-1:0] w_frac;
    logic [PROD_W-1:0] w_prod;

    assign w_char    = sumlog[SUM_W-1:FRAC_W];
    assign w_frac    = sumlog[FRAC_W-1:0];

    // Stage 2 can take a new item when empty or draining this cycle;
    // stage 1 can take one when empty or moving into stage 2.
    assign w_s2_load = !r_s2_valid || out_ready;
    assign w_s1_adv  = r_s1_valid && w_s2_load;
    assign in_ready  = !r_s1_valid || w_s2_load;
    assign w_accept  = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else begin
            if (in_ready)
                r_s1_valid <= in_valid;
            if (w_accept) begin
                r_s1.m   <= {1'b1, w_frac};
                r_s1.sh  <= w_char;
                r_s1.z   <= in_zero;
                r_s1.sat <= (w_char == CHAR_SAT);
            end
        end
    end

    antilog_shift u_shift (
        .i_m       (r_s1.m),
        .i_sh      (r_s1.sh),
        .i_z       (r_s1.z),
        .i_sat     (r_s1.sat),
        .o_product (w_prod)
    );

    // Product only changes when a new item enters, so it stays stable
    // under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid   <= 1'b0;
            r_s2_product <= '0;
        end else begin
            if (w_s2_load)
                r_s2_valid <= r_s1_valid;
            if (w_s1_adv)
                r_s2_product <= w_prod;
        end
    end

    assign out_valid = r_s2_valid;
    assign product   = r_s2_product;

endmodule

// File: tb/tb_antilog_pipe.sv
// tb_antilog_pipe: directed + randomized bench for antilog_pipe with a
// queue scoreboard fed by an arithmetic reference model.
module tb_antilog_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [19:0] sumlog = '0;
    logic        in_zero = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] product;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] expq[$];
    logic last_acc;

    antilog_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sumlog    (sumlog),
        .in_zero   (in_zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    always #5 clk = ~clk;

    // (1 + frac/2^15) * 2^char, floored; char 31 saturates, zero wins.
    function automatic logic [31:0] ref_prod(input logic [19:0] s, input logic z);
        longint unsigned c, f, v;
        c = longint'(s[19:15]);
        f = longint'(s[14:0]);
        if (z) return 32'd0;
        if (c == 31) return 32'hFFFF_FFFF;
        v = ((64'd32768 + f) * (64'd2 ** c)) / 64'd32768;
        return v[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge with inputs set; evaluates the
    // handshakes that will complete on the coming rising edge.
    task automatic tick();
        logic acc, drn;
        logic [31:0] e;
        #1;
        acc = in_valid && in_ready;
        drn = out_valid && out_ready;
        if (drn) begin
            if (expq.size() == 0)
                chk("sb_unexpected_output", 32'(expq.size()), 32'd1);
            else begin
                e = expq.pop_front();
                chk("sb_product", product, e);
            end
        end
        if (acc) expq.push_back(ref_prod(sumlog, in_zero));
        last_acc = acc;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < budget && expq.size() != 0; i++) tick();
        chk("drain_empty", 32'(expq.size()), 32'd0);
    endtask

    // One item sent alone with out_ready high; checks latency and value.
    task automatic single(input string tag, input logic [19:0] s, input logic z,
                          input logic [31:0] exp);
        sumlog = s; in_zero = z; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_lat1_valid"}, {31'b0, out_valid}, 32'd0);
        tick();
        chk({tag, "_lat2_valid"}, {31'b0, out_valid}, 32'd1);
        chk({tag, "_value"}, product, exp);
        tick();
    endtask

    initial begin
        logic [31:0] held;
        int accepts;

        // Reset state
        #2;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_product", product, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Basic values and special cases
        single("basic_c3", {5'd3, 15'h4000}, 1'b0, 32'h0000_000C);
        single("basic_c0", {5'd0, 15'h7FFF}, 1'b0, 32'h0000_0001);
        single("basic_c30", {5'd30, 15'h7FFF}, 1'b0, 32'h7FFF_8000);
        single("zero_flag", {5'd20, 15'h1234}, 1'b1, 32'h0000_0000);
        single("sat_c31", {5'd31, 15'h0000}, 1'b0, 32'hFFFF_FFFF);
        single("basic_c14", {5'd14, 15'h0001}, 1'b0, 32'h0000_4000);

        // Streaming: 8 back-to-back powers of two
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid = (k < 8);
            sumlog   = {5'(k), 15'h0};
            in_zero  = 1'b0;
            #1;
            if (k < 8) chk("stream_in_ready", {31'b0, in_ready}, 32'd1);
            chk("stream_out_valid", {31'b0, out_valid}, (k >= 2) ? 32'd1 : 32'd0);
            if (k >= 2) chk("stream_product", product, 32'd1 << (k - 2));
            tick();
        end
        drain(10);

        // Backpressure: only two items fit while the output is stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_zero   = 1'b0;
        sumlog    = {5'd4, 15'h2000};
        accepts   = 0;
        held      = '0;
        for (int k = 0; k < 5; k++) begin
            if (k == 3) held = product;
            if (k == 4) chk("bp_product_hold", product, held);
            tick();
            if (last_acc) begin
                accepts++;
                sumlog = {5'(5 + accepts), 15'(accepts * 4097)};
            end
        end
        chk("bp_accepts", 32'(accepts), 32'd2);
        #1;
        chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_product_first", product, ref_prod({5'd4, 15'h2000}, 1'b0));
        out_ready = 1'b1;
        tick();   // third item accepted as the pipe drains
        drain(10);

        // Reset with two items in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        sumlog    = {5'd10, 15'h0};
        tick();
        sumlog    = {5'd11, 15'h0};
        tick();
        in_valid  = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_product", product, 32'd0);
        expq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("midrst_no_ghost", {31'b0, out_valid}, 32'd0);
            tick();
        end

        // Random traffic against the scoreboard
        in_valid = 1'b0;
        last_acc = 1'b0;
        for (int k = 0; k < 10000; k++) begin
            // Hold the offered item until it is taken.
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                sumlog   = 20'($urandom);
                in_zero  = ($urandom_range(0, 7) == 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
